// File: rtl/pdm_capture_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : pdm_capture_ctrl_if
// Description : Valid/ready sample stream from the PDM capture controller
//               to the audio pipeline.
// Revision    : 1.0 - initial release
// ============================================================================
interface pdm_capture_ctrl_if #(
    parameter int DW = 16
) ();
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          out_ready;

    modport master (
        output out_data,
        output out_valid,
        input  out_ready
    );

    modport slave (
        input  out_data,
        input  out_valid,
        output out_ready
    );
endinterface
`default_nettype wire

// File: rtl/pdm_capture_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pdm_capture_ctrl
// Description : PDM mic / CIC sequencer with wake-up wait, settling discard,
//               gain shift with saturation and an output FIFO. Defining
//               PDM_DC_BLOCK_EN inserts a DC blocker after saturation.
// Revision    : 1.0 - initial release
// ============================================================================
module pdm_capture_ctrl #(
    parameter int WAKE_CYCLES = 23040,
    parameter int DISCARD     = 4,
    parameter int DEPTH       = 4,
    parameter int DW          = 16
) (
    input  wire logic          clk,
    input  wire logic          rst,
    input  wire logic          start,
    input  wire logic          stop,
    input  wire logic [2:0]    gain_shift,
    output logic               mic_en,
    input  wire logic          mic_pdm,
    output logic               cic_rst_n,
    output logic               cic_pdm_in,
    input  wire logic [DW-1:0] cic_dout,
    input  wire logic          cic_dout_valid,
    pdm_capture_ctrl_if.master out_if,
    output logic [1:0]         state_o,
    output logic               overflow,
    output logic [7:0]         drop_count
);

    localparam logic [1:0] c_IDLE   = 2'd0;
    localparam logic [1:0] c_WAKE   = 2'd1;
    localparam logic [1:0] c_SETTLE = 2'd2;
    localparam logic [1:0] c_RUN    = 2'd3;

    localparam int c_WCW       = $clog2(WAKE_CYCLES + 1);
    localparam int c_DCW       = (DISCARD > 1) ? $clog2(DISCARD) : 1;
    localparam int c_DLAST     = (DISCARD > 0) ? DISCARD - 1 : 0;
    localparam bit c_NO_SETTLE = (DISCARD == 0);
    localparam int c_AW        = $clog2(DEPTH);
    localparam int c_XW        = DW + 7;

    localparam logic [c_WCW-1:0] c_WAKE_LOAD = c_WCW'(WAKE_CYCLES - 1);
    localparam logic [c_DCW-1:0] c_DISC_LAST = c_DCW'(c_DLAST);

    localparam logic signed [c_XW-1:0] c_XMAX = {{8{1'b0}}, {(DW-1){1'b1}}};
    localparam logic signed [c_XW-1:0] c_XMIN = {{8{1'b1}}, {(DW-1){1'b0}}};

    // ------------------------------------------------------------------
    // Sequencer
    // ------------------------------------------------------------------
    logic [1:0]       r_state,     w_state_nxt;
    logic [c_WCW-1:0] r_wake_cnt,  w_wake_nxt;
    logic [c_DCW-1:0] r_disc_cnt,  w_disc_nxt;
    logic [2:0]       r_gain;
    logic             r_mic_en;
    logic             r_cic_rst_n;
    logic             r_pdm;
    logic             w_start_ok;
    logic             w_take;

    assign w_start_ok = (r_state == c_IDLE) && start && !stop;
    // A stop cycle swallows any sample arriving alongside it.
    assign w_take     = (r_state == c_RUN) && cic_dout_valid && !stop;

    always_comb begin
        w_state_nxt = r_state;
        w_wake_nxt  = r_wake_cnt;
        w_disc_nxt  = r_disc_cnt;
        case (r_state)
            c_IDLE: begin
                if (w_start_ok) begin
                    w_state_nxt = c_WAKE;
                    w_wake_nxt  = c_WAKE_LOAD;
                end
            end
            c_WAKE: begin
                if (stop) begin
                    w_state_nxt = c_IDLE;
                end else if (r_wake_cnt == '0) begin
                    w_state_nxt = c_NO_SETTLE ? c_RUN : c_SETTLE;
                    w_disc_nxt  = '0;
                end else begin
                    w_wake_nxt = r_wake_cnt - 1'b1;
                end
            end
            c_SETTLE: begin
                if (stop) begin
                    w_state_nxt = c_IDLE;
                end else if (cic_dout_valid) begin
                    if (r_disc_cnt == c_DISC_LAST) begin
                        w_state_nxt = c_RUN;
                    end else begin
                        w_disc_nxt = r_disc_cnt + 1'b1;
                    end
                end
            end
            default: begin
                if (stop) begin
                    w_state_nxt = c_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= c_IDLE;
            r_wake_cnt  <= '0;
            r_disc_cnt  <= '0;
            r_gain      <= '0;
            r_mic_en    <= 1'b0;
            r_cic_rst_n <= 1'b0;
            r_pdm       <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_wake_cnt  <= w_wake_nxt;
            r_disc_cnt  <= w_disc_nxt;
            if (w_start_ok) begin
                r_gain <= gain_shift;
            end
            r_mic_en    <= (w_state_nxt != c_IDLE);
            r_cic_rst_n <= (w_state_nxt == c_SETTLE) || (w_state_nxt == c_RUN);
            r_pdm       <= (w_state_nxt != c_IDLE) ? mic_pdm : 1'b0;
        end
    end

    assign state_o    = r_state;
    assign mic_en     = r_mic_en;
    assign cic_rst_n  = r_cic_rst_n;
    assign cic_pdm_in = r_pdm;

    // ------------------------------------------------------------------
    // Gain shift with saturation
    // ------------------------------------------------------------------
    logic signed [c_XW-1:0] w_ext;
    logic signed [c_XW-1:0] w_shift;
    logic        [DW-1:0]   w_sat;

    assign w_ext   = signed'({{7{cic_dout[DW-1]}}, cic_dout});
    assign w_shift = w_ext <<< r_gain;

    always_comb begin
        w_sat = w_shift[DW-1:0];
        if (w_shift > c_XMAX) begin
            w_sat = {1'b0, {(DW-1){1'b1}}};
        end else if (w_shift < c_XMIN) begin
            w_sat = {1'b1, {(DW-1){1'b0}}};
        end
    end

    logic          w_push;
    logic [DW-1:0] w_push_data;

`ifdef PDM_DC_BLOCK_EN
    // ------------------------------------------------------------------
    // DC blocker: y[n] = x[n] - x[n-1] + y[n-1] - (y[n-1] >>> 8)
    // ------------------------------------------------------------------
    localparam logic signed [DW+1:0] c_YMAX = {3'b000, {(DW-1){1'b1}}};
    localparam logic signed [DW+1:0] c_YMIN = {3'b111, {(DW-1){1'b0}}};

    logic                 r_dc_vld;
    logic        [DW-1:0] r_dc_x;
    logic        [DW-1:0] r_dc_x1;
    logic        [DW-1:0] r_dc_y1;
    logic signed [DW+1:0] w_dc_sum;
    logic        [DW-1:0] w_dc_out;
    logic signed [DW-1:0] w_y1_shr;
    logic                 w_run_entry;

    assign w_y1_shr    = signed'(r_dc_y1) >>> 8;
    assign w_dc_sum    = signed'({{2{r_dc_x[DW-1]}},   r_dc_x})
                       - signed'({{2{r_dc_x1[DW-1]}},  r_dc_x1})
                       + signed'({{2{r_dc_y1[DW-1]}},  r_dc_y1})
                       - signed'({{2{w_y1_shr[DW-1]}}, w_y1_shr});
    assign w_run_entry = (w_state_nxt == c_RUN) && (r_state != c_RUN);

    always_comb begin
        w_dc_out = w_dc_sum[DW-1:0];
        if (w_dc_sum > c_YMAX) begin
            w_dc_out = {1'b0, {(DW-1){1'b1}}};
        end else if (w_dc_sum < c_YMIN) begin
            w_dc_out = {1'b1, {(DW-1){1'b0}}};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_dc_vld <= 1'b0;
            r_dc_x   <= '0;
            r_dc_x1  <= '0;
            r_dc_y1  <= '0;
        end else begin
            r_dc_vld <= w_take;
            if (w_take) begin
                r_dc_x <= w_sat;
            end
            if (w_run_entry) begin
                r_dc_x1 <= '0;
                r_dc_y1 <= '0;
            end else if (r_dc_vld) begin
                r_dc_x1 <= r_dc_x;
                r_dc_y1 <= w_dc_out;
            end
        end
    end

    assign w_push      = r_dc_vld;
    assign w_push_data = w_dc_out;
`else
    assign w_push      = w_take;
    assign w_push_data = w_sat;
`endif

    // ------------------------------------------------------------------
    // Output FIFO
    // ------------------------------------------------------------------
    logic [DW-1:0]   r_mem [DEPTH];
    logic [c_AW:0]   r_wr_ptr;
    logic [c_AW:0]   r_rd_ptr;
    logic [DW-1:0]   r_hold;
    logic            r_overflow;
    logic [7:0]      r_drop_cnt;
    logic [c_AW:0]   w_count;
    logic            w_empty;
    logic            w_full;
    logic            w_pop;
    logic            w_wr_en;
    logic            w_drop;

    assign w_count = r_wr_ptr - r_rd_ptr;
    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (w_count == (c_AW+1)'(DEPTH));
    assign w_pop   = !w_empty && out_if.out_ready;
    // A pop in the same cycle frees the slot a full-FIFO push needs.
    assign w_wr_en = w_push && (!w_full || w_pop);
    assign w_drop  = w_push && w_full && !w_pop;

    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem[r_wr_ptr[c_AW-1:0]] <= w_push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_hold     <= '0;
            r_overflow <= 1'b0;
            r_drop_cnt <= '0;
        end else begin
            if (w_wr_en) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
                r_hold   <= r_mem[r_rd_ptr[c_AW-1:0]];
            end
            if (w_start_ok) begin
                r_overflow <= 1'b0;
                r_drop_cnt <= '0;
            end else if (w_drop) begin
                r_overflow <= 1'b1;
                if (r_drop_cnt != 8'hFF) begin
                    r_drop_cnt <= r_drop_cnt + 1'b1;
                end
            end
        end
    end

    // An empty FIFO keeps showing the last sample handed downstream.
    assign out_if.out_data  = w_empty ? r_hold : r_mem[r_rd_ptr[c_AW-1:0]];
    assign out_if.out_valid = !w_empty;
    assign overflow         = r_overflow;
    assign drop_count       = r_drop_cnt;

endmodule
`default_nettype wire

// File: tb/tb_pdm_capture_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_pdm_capture_ctrl
// Description : Self-checking bench for pdm_capture_ctrl (default build).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pdm_capture_ctrl;

    localparam int c_WAKE  = 16;
    localparam int c_DISC  = 4;
    localparam int c_DEPTH = 4;
    localparam int c_DW    = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        stop;
    logic [2:0]  gain_shift;
    logic        mic_en;
    logic        mic_pdm;
    logic        cic_rst_n;
    logic        cic_pdm_in;
    logic [15:0] cic_dout;
    logic        cic_dout_valid;
    logic [1:0]  state_o;
    logic        overflow;
    logic [7:0]  drop_count;

    int n_tests = 0;
    int n_fail  = 0;

    pdm_capture_ctrl_if #(.DW(c_DW)) u_if ();

    pdm_capture_ctrl #(
        .WAKE_CYCLES (c_WAKE),
        .DISCARD     (c_DISC),
        .DEPTH       (c_DEPTH),
        .DW          (c_DW)
    ) u_dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .stop           (stop),
        .gain_shift     (gain_shift),
        .mic_en         (mic_en),
        .mic_pdm        (mic_pdm),
        .cic_rst_n      (cic_rst_n),
        .cic_pdm_in     (cic_pdm_in),
        .cic_dout       (cic_dout),
        .cic_dout_valid (cic_dout_valid),
        .out_if         (u_if.master),
        .state_o        (state_o),
        .overflow       (overflow),
        .drop_count     (drop_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  gain;
        logic [15:0] din;
        logic [15:0] expv;
    } vec_t;

    vec_t vecs[12];

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    task automatic wait_state(input logic [1:0] tgt, input int budget, input string name);
        for (int i = 0; i < budget; i++) begin
            if (state_o == tgt) break;
            cyc();
        end
        check(name, 32'(state_o), 32'(tgt));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
    endtask

    task automatic pulse_valid(input logic [15:0] d);
        cic_dout       = d;
        cic_dout_valid = 1'b1;
        cyc();
        cic_dout_valid = 1'b0;
    endtask

    task automatic bring_up(input logic [2:0] g);
        start      = 1'b1;
        gain_shift = g;
        cyc();
        start      = 1'b0;
        gain_shift = 3'($urandom_range(0, 7));
        wait_state(2'd2, 40, "reach_settle");
        for (int i = 0; i < c_DISC; i++) begin
            pulse_valid(16'($urandom));
            cyc();
        end
        wait_state(2'd3, 4, "reach_run");
    endtask

    // Reference: sample * 2^gain clamped to the 16-bit signed range.
    function automatic logic [15:0] ref_proc(input logic [15:0] d, input int g);
        longint x;
        x = longint'($signed(d)) * (longint'(1) <<< g);
        if (x > 32767)  x = 32767;
        if (x < -32768) x = -32768;
        return 16'(x);
    endfunction

    initial begin
        logic [15:0] q[$];
        int          drops;
        int          n;
        logic [15:0] expo[5];

        rst = 1'b1; start = 1'b0; stop = 1'b0; gain_shift = 3'd0;
        mic_pdm = 1'b0; cic_dout = '0; cic_dout_valid = 1'b0;
        u_if.out_ready = 1'b0;

        vecs[0]  = '{3'd3, 16'sd1000,   16'sd8000};
        vecs[1]  = '{3'd3, 16'sd5000,   16'sd32767};
        vecs[2]  = '{3'd3, -16'sd5000,  -16'sd32768};
        vecs[3]  = '{3'd0, -16'sd1,     -16'sd1};
        vecs[4]  = '{3'd7, 16'sd255,    16'sd32640};
        vecs[5]  = '{3'd7, 16'sd256,    16'sd32767};
        vecs[6]  = '{3'd1, -16'sd16384, -16'sd32768};
        vecs[7]  = '{3'd1, -16'sd16385, -16'sd32768};
        vecs[8]  = '{3'd0, 16'sd32767,  16'sd32767};
        vecs[9]  = '{3'd2, -16'sd8192,  -16'sd32768};
        vecs[10] = '{3'd2, -16'sd8193,  -16'sd32768};
        vecs[11] = '{3'd4, -16'sd2047,  -16'sd32752};

        @(negedge clk);
        cyc();
        rst = 1'b0;
        check("rst_state",     32'(state_o),        32'd0);
        check("rst_mic_en",    32'(mic_en),         32'd0);
        check("rst_cic_rst_n", 32'(cic_rst_n),      32'd0);
        check("rst_pdm",       32'(cic_pdm_in),     32'd0);
        check("rst_valid",     32'(u_if.out_valid), 32'd0);
        check("rst_data",      32'(u_if.out_data),  32'd0);
        check("rst_ovf",       32'(overflow),       32'd0);
        check("rst_drops",     32'(drop_count),     32'd0);

        // Startup timing: WAKE length, settle discards, first sample.
        start = 1'b1; gain_shift = 3'd0;
        cyc();
        start = 1'b0;
        n = 0;
        while (state_o == 2'd1 && n < 100) begin
            if (cic_rst_n !== 1'b0 || mic_en !== 1'b1) check("wake_outputs", {cic_rst_n, mic_en}, 32'b01);
            n++;
            cyc();
        end
        check("wake_len",        32'(n),         32'(c_WAKE));
        check("settle_state",    32'(state_o),   32'd2);
        check("settle_cic_rst",  32'(cic_rst_n), 32'd1);
        for (int i = 0; i < c_DISC; i++) begin
            pulse_valid(16'(i + 100));
            check("settle_no_push", 32'(u_if.out_valid), 32'd0);
        end
        check("run_state", 32'(state_o), 32'd3);
        pulse_valid(16'h0123);
        check("first_valid", 32'(u_if.out_valid), 32'd1);
        check("first_data",  32'(u_if.out_data),  32'h0123);
        mic_pdm = 1'b1;
        cyc();
        check("pdm_pass_hi", 32'(cic_pdm_in), 32'd1);
        mic_pdm = 1'b0;
        cyc();
        check("pdm_pass_lo", 32'(cic_pdm_in), 32'd0);

        // Gain / saturation table.
        for (int v = 0; v < 12; v++) begin
            do_reset();
            bring_up(vecs[v].gain);
            pulse_valid(vecs[v].din);
            check($sformatf("gain_vec%0d_valid", v), 32'(u_if.out_valid), 32'd1);
            check($sformatf("gain_vec%0d_data", v),  32'(u_if.out_data),  32'(vecs[v].expv));
        end

        // Overflow, then a full-FIFO push with a concurrent pop.
        do_reset();
        bring_up(3'd0);
        for (int i = 1; i <= 6; i++) pulse_valid(16'(i));
        check("ovf_flag",  32'(overflow),   32'd1);
        check("ovf_drops", 32'(drop_count), 32'd2);
        check("ovf_head",  32'(u_if.out_data), 32'd1);
        u_if.out_ready = 1'b1;
        pulse_valid(16'd7);
        check("ovf_pop_push_drops", 32'(drop_count), 32'd2);
        expo = '{16'd2, 16'd3, 16'd4, 16'd7, 16'd0};
        for (int i = 0; i < 4; i++) begin
            check($sformatf("drain%0d", i), 32'(u_if.out_data), 32'(expo[i]));
            cyc();
        end
        check("drain_empty", 32'(u_if.out_valid), 32'd0);
        check("drain_hold",  32'(u_if.out_data),  32'd7);
        u_if.out_ready = 1'b0;

        // start+stop together in IDLE, stop in SETTLE.
        do_reset();
        start = 1'b1; stop = 1'b1;
        cyc();
        start = 1'b0; stop = 1'b0;
        check("startstop_idle", 32'(state_o), 32'd0);
        start = 1'b1;
        cyc();
        start = 1'b0;
        wait_state(2'd2, 40, "stop_reach_settle");
        stop = 1'b1; mic_pdm = 1'b1;
        cyc();
        stop = 1'b0;
        check("stop_state",   32'(state_o),    32'd0);
        check("stop_mic_en",  32'(mic_en),     32'd0);
        check("stop_cic_rst", 32'(cic_rst_n),  32'd0);
        check("stop_pdm",     32'(cic_pdm_in), 32'd0);
        mic_pdm = 1'b0;

        // Stop in RUN keeps the FIFO, drops the coincident sample.
        bring_up(3'd1);
        pulse_valid(16'd10);
        pulse_valid(16'd20);
        cic_dout = 16'd30; cic_dout_valid = 1'b1; stop = 1'b1;
        cyc();
        cic_dout_valid = 1'b0; stop = 1'b0;
        check("runstop_state", 32'(state_o),    32'd0);
        check("runstop_drops", 32'(drop_count), 32'd0);
        u_if.out_ready = 1'b1;
        check("runstop_d0", 32'(u_if.out_data), 32'd20);
        cyc();
        check("runstop_d1", 32'(u_if.out_data), 32'd40);
        cyc();
        check("runstop_empty", 32'(u_if.out_valid), 32'd0);
        u_if.out_ready = 1'b0;

        // Reset mid-RUN with three entries queued.
        bring_up(3'd0);
        for (int i = 0; i < 3; i++) pulse_valid(16'(i + 1));
        check("prerst_valid", 32'(u_if.out_valid), 32'd1);
        do_reset();
        check("midrst_valid", 32'(u_if.out_valid), 32'd0);
        check("midrst_state", 32'(state_o),        32'd0);
        check("midrst_drops", 32'(drop_count),     32'd0);
        check("midrst_mic",   32'(mic_en),         32'd0);

        // Randomized traffic against a queue model.
        for (int pass = 0; pass < 3; pass++) begin
            int g;
            g = $urandom_range(0, 7);
            bring_up(3'(g));
            drops = 0;
            while (q.size() != 0) void'(q.pop_front());
            for (int c = 0; c < 400; c++) begin
                logic        v, r, popped;
                logic [15:0] d;
                check("rnd_valid", 32'(u_if.out_valid), 32'(q.size() != 0));
                if (q.size() != 0) check("rnd_data", 32'(u_if.out_data), 32'(q[0]));
                check("rnd_drops", 32'(drop_count), 32'((drops > 255) ? 255 : drops));
                check("rnd_ovf",   32'(overflow),   32'(drops > 0));
                v = ($urandom_range(0, 99) < 55);
                r = ($urandom_range(0, 99) < (pass == 1 ? 20 : 60));
                d = 16'($urandom);
                cic_dout = d; cic_dout_valid = v; u_if.out_ready = r;
                popped = (q.size() != 0) && r;
                if (popped) void'(q.pop_front());
                if (v) begin
                    if (q.size() < c_DEPTH) q.push_back(ref_proc(d, g));
                    else drops++;
                end
                cyc();
            end
            cic_dout_valid = 1'b0;
            u_if.out_ready = 1'b1;
            repeat (c_DEPTH + 1) cyc();
            u_if.out_ready = 1'b0;
            stop = 1'b1;
            cyc();
            stop = 1'b0;
        end

        // Drop counter saturation.
        bring_up(3'd0);
        check("restart_clears_drops", 32'(drop_count), 32'd0);
        cic_dout_valid = 1'b1; cic_dout = 16'h5555;
        repeat (c_DEPTH + 260) cyc();
        cic_dout_valid = 1'b0;
        check("drops_saturate", 32'(drop_count), 32'd255);
        check("drops_ovf",      32'(overflow),   32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
